// File: rtl/prog_ctr_if.sv
// Decode/control bundle between the core's instruction decoder and the
// program-counter / branch unit, plus the PC and status outputs it drives back.
interface prog_ctr_if #(
  parameter int PC_W      = 10,
  parameter int LUT_DEPTH = 16
);
  localparam int IDX_W = (LUT_DEPTH > 1) ? $clog2(LUT_DEPTH) : 1;

  logic             Start;
  logic             Stall;
  logic             Halt;
  logic             JumpEn;
  logic             BranchEn;
  logic [IDX_W-1:0] TargetIdx;
  logic             FlagWe;
  logic             Cond;
  logic             LutWe;
  logic [IDX_W-1:0] LutAddr;
  logic [PC_W-1:0]  LutData;
  logic [PC_W-1:0]  PC;
  logic             Flag;
  logic             Running;
  logic             Done;
  logic [1:0]       DbgState;

  modport master (
    output Start, Stall, Halt, JumpEn, BranchEn, TargetIdx, FlagWe, Cond,
           LutWe, LutAddr, LutData,
    input  PC, Flag, Running, Done, DbgState
  );

  modport slave (
    input  Start, Stall, Halt, JumpEn, BranchEn, TargetIdx, FlagWe, Cond,
           LutWe, LutAddr, LutData,
    output PC, Flag, Running, Done, DbgState
  );
endinterface

// File: rtl/prog_ctr.sv
// Program counter and branch unit: IDLE/RUN/HALTED sequencing, branch flag
// captured from the ALU compare, and a programmable jump-target table.
module prog_ctr #(
  parameter int PC_W       = 10,
  parameter int LUT_DEPTH  = 16,
  parameter int START_ADDR = 0
) (
  input  logic      Clk,
  input  logic      Reset_n,
  prog_ctr_if.slave bus
);
  localparam int IDX_W = (LUT_DEPTH > 1) ? $clog2(LUT_DEPTH) : 1;
  localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            flag_q, flag_d;
  logic            done_q, done_d;
  logic [PC_W-1:0] lut_q [LUT_DEPTH];
  logic [PC_W-1:0] target;
  logic            lut_wr_ok;

  // Only a non-power-of-two table can be addressed past its end.
  if (LUT_DEPTH == (1 << IDX_W)) begin : g_full_idx
    assign target    = lut_q[bus.TargetIdx];
    assign lut_wr_ok = 1'b1;
  end else begin : g_part_idx
    assign target    = ({1'b0, bus.TargetIdx} < (IDX_W+1)'(LUT_DEPTH)) ?
                       lut_q[bus.TargetIdx] : '0;
    assign lut_wr_ok = ({1'b0, bus.LutAddr} < (IDX_W+1)'(LUT_DEPTH));
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    flag_d  = flag_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        pc_d = START_PC;
        if (bus.Start) begin
          state_d = ST_RUN;
          flag_d  = 1'b0;
        end
      end
      ST_RUN: begin
        if (bus.Halt) begin
          state_d = ST_HALTED;
          done_d  = 1'b1;
        end else if (!bus.Stall) begin
          // Branch decision uses the flag from before this edge.
          if (bus.JumpEn || (bus.BranchEn && flag_q)) pc_d = target;
          else                                        pc_d = pc_q + PC_W'(1);
          if (bus.FlagWe) flag_d = bus.Cond;
        end
      end
      ST_HALTED: begin
        if (bus.Start) begin
          state_d = ST_RUN;
          pc_d    = START_PC;
          flag_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        pc_d    = START_PC;
        flag_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
      pc_q    <= START_PC;
      flag_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      flag_q  <= flag_d;
      done_q  <= done_d;
    end
  end

  // Table writes are accepted in every state, including IDLE and HALTED.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < LUT_DEPTH; i++) lut_q[i] <= '0;
    end else if (bus.LutWe && lut_wr_ok) begin
      lut_q[bus.LutAddr] <= bus.LutData;
    end
  end

  assign bus.PC       = pc_q;
  assign bus.Flag     = flag_q;
  assign bus.Running  = (state_q == ST_RUN);
  assign bus.Done     = done_q;
  assign bus.DbgState = state_q;
endmodule
